// File: rtl/mux4_rr_arbiter_pkg.sv
// rtl/mux4_rr_arbiter_pkg.sv - shared state encodings, sizes and helpers for the 4-way round-robin arbiter
package mux4_rr_arbiter_pkg;

    localparam int REQ_N = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [REQ_N-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        return REQ_N'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface mux4_rr_arbiter_if;
    import mux4_rr_arbiter_pkg::*;

    logic [REQ_N-1:0] req_i;
    logic             done_i;
    logic [REQ_N-1:0] gnt_o;
    logic [SEL_W-1:0] sel_o;
    logic             busy_o;
    logic             timeout_o;

    modport master (
        output req_i, done_i,
        input  gnt_o, sel_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i, done_i,
        output gnt_o, sel_o, busy_o, timeout_o
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rtl/mux4_rr_arbiter_rr_pick4.sv - combinational first-set scan of req starting at ptr, wrapping 3->0
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 0; i < REQ_N; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving the select of a shared 4:1 mux
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mux4_rr_arbiter_if.slave   arb
);

    arb_state_e       state_q, state_d;
    logic [REQ_N-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             timeout_q, timeout_d;

    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             release_now;
    logic             timeout_hit;
    logic             new_grant;

    // Counter must be able to reach HOLD_MAX-1; a bad pairing leaves this marker block in the hierarchy.
    if ((HOLD_MAX < 1) || ((1 << CNT_W) < HOLD_MAX)) begin : g_bad_hold_cfg
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (state_q == ST_GRANT) && (cnt_q == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (new_grant) begin
            cnt_d = '0;
        end else if (state_q == ST_GRANT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // While granted, the scan starts just past the owner so a re-pick on release is already rotated.
    assign pick_ptr = (state_q == ST_GRANT) ? (sel_q + SEL_W'(1)) : ptr_q;

    rr_pick4 u_pick (
        .req   (arb.req_i),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        timeout_d   = 1'b0;
        new_grant   = 1'b0;
        release_now = (state_q == ST_GRANT) &&
                      (arb.done_i || !arb.req_i[sel_q] || timeout_hit);

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d   = ST_GRANT;
                    gnt_d     = idx_to_onehot(pick_idx);
                    sel_d     = pick_idx;
                    new_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    ptr_d     = pick_ptr;
                    timeout_d = timeout_hit && !arb.done_i && arb.req_i[sel_q];
                    if (pick_found) begin
                        gnt_d     = idx_to_onehot(pick_idx);
                        sel_d     = pick_idx;
                        new_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign arb.gnt_o     = gnt_q;
    assign arb.sel_o     = sel_q;
    assign arb.busy_o    = (state_q == ST_GRANT);
    assign arb.timeout_o = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed vector bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if arb_if ();

    mux4_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .arb   (arb_if)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        string      tag;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(input logic r, input logic [3:0] q, input logic d,
                                input logic [3:0] g, input logic [1:0] s, input logic b,
                                input string t);
        vec_t v;
        v.rst = r; v.req = q; v.done = d; v.gnt = g; v.sel = s; v.busy = b; v.tag = t;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] q, input logic d);
        rst           = r;
        arb_if.req_i  = q;
        arb_if.done_i = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic t);
        check({tag, ".gnt"},     32'(arb_if.gnt_o),     32'(g));
        check({tag, ".sel"},     32'(arb_if.sel_o),     32'(s));
        check({tag, ".busy"},    32'(arb_if.busy_o),    32'(b));
        check({tag, ".timeout"}, 32'(arb_if.timeout_o), 32'(t));
        check({tag, ".onehot0"}, 32'($onehot0(arb_if.gnt_o)), 32'd1);
        check({tag, ".gnt_vs_busy"}, 32'(arb_if.gnt_o != 4'd0), 32'(arb_if.busy_o));
    endtask

    initial begin
        rst           = 1'b1;
        arb_if.req_i  = 4'b0000;
        arb_if.done_i = 1'b0;

        // reset held with all requests active
        add(1, 4'b1111, 0, 4'b0000, 2'd0, 0, "reset0");
        add(1, 4'b1111, 0, 4'b0000, 2'd0, 0, "reset1");
        add(1, 4'b1111, 1, 4'b0000, 2'd0, 0, "reset2");
        // single request, release with done, sel holds while idle, done ignored idle
        add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, "single_gnt");
        add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, "single_hold");
        add(0, 4'b0000, 1, 4'b0000, 2'd2, 0, "single_done");
        add(0, 4'b0000, 1, 4'b0000, 2'd2, 0, "idle_done_ignored");
        add(0, 4'b0000, 0, 4'b0000, 2'd2, 0, "idle_sel_holds");
        // rotation with all requesting, done every third cycle
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "rot_reset");
        add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, "rot0a");
        add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, "rot0b");
        add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, "rot0c");
        add(0, 4'b1111, 1, 4'b0010, 2'd1, 1, "rot1a");
        add(0, 4'b1111, 0, 4'b0010, 2'd1, 1, "rot1b");
        add(0, 4'b1111, 0, 4'b0010, 2'd1, 1, "rot1c");
        add(0, 4'b1111, 1, 4'b0100, 2'd2, 1, "rot2a");
        add(0, 4'b1111, 0, 4'b0100, 2'd2, 1, "rot2b");
        add(0, 4'b1111, 0, 4'b0100, 2'd2, 1, "rot2c");
        add(0, 4'b1111, 1, 4'b1000, 2'd3, 1, "rot3a");
        add(0, 4'b1111, 0, 4'b1000, 2'd3, 1, "rot3b");
        add(0, 4'b1111, 0, 4'b1000, 2'd3, 1, "rot3c");
        add(0, 4'b1111, 1, 4'b0001, 2'd0, 1, "rot0_again");
        // owner drop / priority
        add(0, 4'b1011, 1, 4'b0010, 2'd1, 1, "drop_owner1");
        add(0, 4'b1111, 0, 4'b0010, 2'd1, 1, "nonowner_change");
        add(0, 4'b1001, 0, 4'b1000, 2'd3, 1, "drop_to3");
        add(0, 4'b1001, 1, 4'b0001, 2'd0, 1, "drop_to0");
        add(0, 4'b1001, 1, 4'b1000, 2'd3, 1, "drop_wrap3");
        add(0, 4'b0001, 1, 4'b0001, 2'd0, 1, "old_owner_last");
        // reset mid-grant with ptr away from 0
        add(0, 4'b0110, 1, 4'b0010, 2'd1, 1, "mid_to1");
        add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, "mid_to2");
        add(1, 4'b1111, 0, 4'b0000, 2'd0, 0, "mid_reset");
        add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, "post_reset_gnt0");

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].req, vecs[i].done);
            check_outs(vecs[i].tag, vecs[i].gnt, vecs[i].sel, vecs[i].busy, 1'b0);
        end

        // hold with two requesters and no done
        apply(1, 4'b0000, 0);
        check_outs("hold_reset", 4'b0000, 2'd0, 0, 0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            apply(0, 4'b0011, 0);
            check_outs($sformatf("hold_owner0_%0d", c), 4'b0001, 2'd0, 1, 0);
        end
        apply(0, 4'b0011, 0);
        check_outs("timeout_pulse", 4'b0010, 2'd1, 1, 1);
        apply(0, 4'b0011, 0);
        check_outs("timeout_cleared", 4'b0010, 2'd1, 1, 0);
`else
        for (int c = 0; c < 55; c++) begin
            apply(0, 4'b0011, 0);
            check_outs($sformatf("hold_owner0_%0d", c), 4'b0001, 2'd0, 1, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
